// File: rtl/ann_pkg.sv
// Shared definitions for the neuron weight path: default widths and the reader FSM state encoding.
package ann_pkg;

  localparam int unsigned WEIGHT_W  = 16;
  localparam int unsigned WADDR_W   = 5;
  localparam int unsigned N_WEIGHTS = 28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } reader_state_t;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO holding weight words between the BRAM read port and the MAC handshake.
// The head entry is read straight from storage, so it stays put while the consumer stalls.
module weight_skid_fifo #(
  parameter int unsigned WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // Storage, pointers and occupancy; caller never pushes when full or pops when empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/weight_bram_reader.sv
// Read-side sequencer for one neuron's weight BRAM: streams N_WORDS weights from address 0
// to the MAC over a valid/ready handshake, flagging the final word with W_LAST.
// Optional feature macro: WEIGHT_LOAD_EN adds an IDLE-time write port (LD_VALID/LD_ADDR/LD_DATA).
module weight_bram_reader
  import ann_pkg::*;
#(
  parameter int unsigned DATA_W  = WEIGHT_W,
  parameter int unsigned ADDR_W  = WADDR_W,
  parameter int unsigned N_WORDS = N_WEIGHTS
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic              BRAM_EN,
  output logic              BRAM_WE,
  output logic [DATA_W-1:0] BRAM_DI,
  input  logic [DATA_W-1:0] BRAM_DO,
  output logic [DATA_W-1:0] W_DATA,
  output logic [ADDR_W-1:0] W_IDX,
  output logic              W_VALID,
  input  logic              W_READY,
`ifdef WEIGHT_LOAD_EN
  input  logic              LD_VALID,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [DATA_W-1:0] LD_DATA,
`endif
  output logic              W_LAST
);

  // One extra bit so a full 2**ADDR_W fetch can count to N_WORDS without wrapping.
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned ENTRY_W = DATA_W + ADDR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } word_t;

  reader_state_t     state;
  logic [CNT_W-1:0]  issue_cnt;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;

  word_t             push_word;
  word_t             head_word;
  logic [1:0]        fifo_count;

  logic              pop_c;
  logic              load_c;
  logic              can_issue_c;
  logic [2:0]        occ_next_c;

  // A read issued this cycle lands in the FIFO at the next edge, tagged with its address.
  assign push_word.data = BRAM_DO;
  assign push_word.idx  = rd_addr_q;
  assign push_word.last = (rd_addr_q == ADDR_W'(N_WORDS - 1));

  weight_skid_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (rd_en_q),
    .push_data (push_word),
    .pop       (pop_c),
    .head      (head_word),
    .count     (fifo_count)
  );

  assign W_VALID = (fifo_count != 2'd0);
  assign W_DATA  = head_word.data;
  assign W_IDX   = head_word.idx;
  assign W_LAST  = head_word.last;
  assign pop_c   = W_VALID && W_READY;

  // Occupancy seen by the next cycle's read: only issue if that read will have a free slot.
  assign occ_next_c  = 3'(fifo_count) + 3'(rd_en_q) - 3'(pop_c);
  assign can_issue_c = (occ_next_c < 3'd2) && (issue_cnt < CNT_W'(N_WORDS));

  // BRAM port: the load path overrides reads only while idle.
`ifdef WEIGHT_LOAD_EN
  assign load_c    = (state == ST_IDLE) && LD_VALID;
  assign BRAM_EN   = rd_en_q | load_c;
  assign BRAM_WE   = load_c;
  assign BRAM_ADDR = load_c ? LD_ADDR : rd_addr_q;
  assign BRAM_DI   = load_c ? LD_DATA : '0;
`else
  assign load_c    = 1'b0;
  assign BRAM_EN   = rd_en_q;
  assign BRAM_WE   = 1'b0;
  assign BRAM_ADDR = rd_addr_q;
  assign BRAM_DI   = '0;
`endif

  // Fetch sequencer: state, issue counter and registered read/status outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      issue_cnt <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      DONE    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START && !load_c) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            issue_cnt <= CNT_W'(1);
            BUSY      <= 1'b1;
            state     <= (N_WORDS == 1) ? ST_DRAIN : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (can_issue_c) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= ADDR_W'(issue_cnt);
            issue_cnt <= issue_cnt + CNT_W'(1);
            if (issue_cnt == CNT_W'(N_WORDS - 1)) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop_c && head_word.last) begin
            DONE  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          BUSY      <= 1'b0;
          issue_cnt <= '0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_bram_reader.sv
// Scoreboard bench for weight_bram_reader: expected words are queued per accepted START and
// a negedge monitor compares every handshake, stall hold, read issue and DONE pulse.
module tb_weight_bram_reader;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 5;
  localparam int N_WORDS = 28;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } exp_word_t;

  logic              CLK;
  logic              RST_N;
  logic              START;
  logic              BUSY;
  logic              DONE;
  logic [ADDR_W-1:0] BRAM_ADDR;
  logic              BRAM_EN;
  logic              BRAM_WE;
  logic [DATA_W-1:0] BRAM_DI;
  logic [DATA_W-1:0] BRAM_DO;
  logic [DATA_W-1:0] W_DATA;
  logic [ADDR_W-1:0] W_IDX;
  logic              W_VALID;
  logic              W_READY;
  logic              W_LAST;

  weight_bram_reader dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .BRAM_ADDR (BRAM_ADDR),
    .BRAM_EN   (BRAM_EN),
    .BRAM_WE   (BRAM_WE),
    .BRAM_DI   (BRAM_DI),
    .BRAM_DO   (BRAM_DO),
    .W_DATA    (W_DATA),
    .W_IDX     (W_IDX),
    .W_VALID   (W_VALID),
    .W_READY   (W_READY),
    .W_LAST    (W_LAST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  // Behavioural BRAM: samples on the falling edge, mem[i] = 0x0100 + i.
  logic [DATA_W-1:0] mem [2**ADDR_W];
  initial begin
    BRAM_DO = '0;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'(16'h0100 + i);
  end
  always @(negedge CLK) begin
    if (BRAM_EN) begin
      if (BRAM_WE) mem[BRAM_ADDR] <= BRAM_DI;
      else         BRAM_DO <= mem[BRAM_ADDR];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_word_t exp_q[$];
  int        issued   = 0;
  int        accepted = 0;
  int        done_cnt = 0;
  int        last_hs  = 0;
  bit        mon_en   = 1'b0;
  bit        done_exp = 1'b0;
  bit        hold_v   = 1'b0;
  bit        tput_chk = 1'b0;
  exp_word_t held;

  // Monitor: one sample per cycle on the falling edge, away from the active edge.
  always @(negedge CLK) begin : monitor
    exp_word_t e;
    if (mon_en) begin
      check("done_pulse", 32'(DONE), 32'(done_exp));
      done_exp = 1'b0;
      if (DONE) done_cnt++;
      check("bram_we_low", 32'(BRAM_WE), 32'd0);
      if (BRAM_EN) begin
        check("issue_occupancy_lt2", 32'((issued - accepted) < 2), 32'd1);
        check("issue_addr", 32'(BRAM_ADDR), 32'(issued));
        issued++;
      end
      if (W_VALID) begin
        if (hold_v) begin
          check("stall_data", 32'(W_DATA), 32'(held.data));
          check("stall_idx",  32'(W_IDX),  32'(held.idx));
          check("stall_last", 32'(W_LAST), 32'(held.last));
        end
        if (W_READY) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got idx %0d data 0x%0h, expected no word (cycle %0d)", W_IDX, W_DATA, cyc);
          end else begin
            e = exp_q.pop_front();
            check("w_data", 32'(W_DATA), 32'(e.data));
            check("w_idx",  32'(W_IDX),  32'(e.idx));
            check("w_last", 32'(W_LAST), 32'(e.last));
            if (e.last) done_exp = 1'b1;
          end
          if (tput_chk && accepted > 0) check("throughput_gap", 32'(cyc - last_hs), 32'd1);
          last_hs = cyc;
          accepted++;
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          held   = {W_DATA, W_IDX, W_LAST};
        end
      end else if (hold_v) begin
        check("valid_held_while_stalled", 32'(W_VALID), 32'd1);
        hold_v = 1'b0;
      end
    end
  end

  // W_READY driver: 0 = always high, 1 = 1,0,0,1 pattern, 2 = random 3/4 high, 3 = held low.
  int rmode = 3;
  int ph    = 0;
  always @(posedge CLK) begin
    #1;
    case (rmode)
      0:       W_READY = 1'b1;
      1:       begin W_READY = ((ph % 4) == 0) || ((ph % 4) == 3); ph++; end
      2:       W_READY = ($urandom_range(0, 3) != 0);
      default: W_READY = 1'b0;
    endcase
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      32'(BUSY),      32'd0);
    check({tag, "_done"},      32'(DONE),      32'd0);
    check({tag, "_bram_en"},   32'(BRAM_EN),   32'd0);
    check({tag, "_bram_we"},   32'(BRAM_WE),   32'd0);
    check({tag, "_bram_addr"}, 32'(BRAM_ADDR), 32'd0);
    check({tag, "_bram_di"},   32'(BRAM_DI),   32'd0);
    check({tag, "_w_valid"},   32'(W_VALID),   32'd0);
    check({tag, "_w_data"},    32'(W_DATA),    32'd0);
    check({tag, "_w_idx"},     32'(W_IDX),     32'd0);
    check({tag, "_w_last"},    32'(W_LAST),    32'd0);
  endtask

  // Issue one START from IDLE and queue the full expected stream.
  task automatic start_fetch();
    issued   = 0;
    accepted = 0;
    hold_v   = 1'b0;
    @(posedge CLK); #1;
    START = 1'b1;
    for (int i = 0; i < N_WORDS; i++)
      exp_q.push_back('{data: DATA_W'(16'h0100 + i), idx: ADDR_W'(i), last: (i == N_WORDS - 1)});
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK); #1;
    check("busy_after_start", 32'(BUSY), 32'd1);
    check("valid_latency_t1", 32'(W_VALID), 32'd0);
    @(negedge CLK); #1;
    check("valid_latency_t2", 32'(W_VALID), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n0   = done_cnt;
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge CLK); #1;
      if (done_cnt > n0) seen = 1'b1;
    end
    repeat (2) @(negedge CLK);
    #1;
    check("done_count", 32'(done_cnt - n0), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("busy_cleared", 32'(BUSY), 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int n0;
    bit seen;
    RST_N   = 1'b0;
    START   = 1'b0;
    W_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RST_N  = 1'b1;
    mon_en = 1'b1;

    // Full-rate stream.
    rmode    = 0;
    W_READY  = 1'b1;
    tput_chk = 1'b1;
    start_fetch();
    wait_done(200);
    tput_chk = 1'b0;

    // 1,0,0,1 backpressure.
    ph    = 0;
    rmode = 1;
    start_fetch();
    wait_done(400);

    // Held off for 10 cycles: only two reads may be outstanding.
    rmode   = 3;
    W_READY = 1'b0;
    start_fetch();
    repeat (10) @(negedge CLK);
    #1;
    check("reads_while_stalled", 32'(issued), 32'd2);
    check("bram_en_low_when_full", 32'(BRAM_EN), 32'd0);
    rmode = 0;
    wait_done(200);

    // Reset mid-fetch after 10 words, then restart.
    rmode = 0;
    start_fetch();
    for (int k = 0; k < 200 && accepted < 10; k++) begin
      @(negedge CLK); #1;
    end
    check("reached_word_10", 32'(accepted >= 10), 32'd1);
    @(posedge CLK); #1;
    mon_en = 1'b0;
    RST_N  = 1'b0;
    exp_q.delete();
    @(posedge CLK); #1;
    check_all_zero("midreset");
    RST_N    = 1'b1;
    issued   = 0;
    accepted = 0;
    done_exp = 1'b0;
    hold_v   = 1'b0;
    mon_en   = 1'b1;
    start_fetch();
    wait_done(200);

    // START pulses while busy and during the DONE cycle must be ignored.
    n0    = done_cnt;
    rmode = 2;
    start_fetch();
    repeat (3) begin
      @(posedge CLK); #1;
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
    end
    check("done_seen_busy_starts", 32'(seen), 32'd1);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (6) @(negedge CLK);
    #1;
    check("ignored_start_busy", 32'(BUSY), 32'd0);
    check("ignored_start_queue", 32'(exp_q.size()), 32'd0);
    check("one_done_per_start", 32'(done_cnt - n0), 32'd1);

    // Randomised backpressure with random idle gaps.
    for (int r = 0; r < 4; r++) begin
      rmode = 2;
      repeat ($urandom_range(0, 5)) @(posedge CLK);
      start_fetch();
      wait_done(600);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
